mixer_fade_ctrl: RTL



---
 rtl/mixer_pkg.sv | 29 ++
 rtl/mixer_fade_ctrl_rr_pick.sv | 27 ++
 rtl/mixer_fade_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mixer_pkg.sv
// Shared definitions for the mixer fade controller: volume width, register
// indices, scheduler state encoding and the volume stepping helper.
package mixer_pkg;

   localparam int VOL_W = 4;

   localparam logic [2:0] CH_CTRL_0 = 3'd0;
   localparam logic [2:0] STATUS    = 3'd7;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_e;

   // One volume step from cur toward tgt; never overshoots and never wraps.
   function automatic logic [VOL_W-1:0] step_toward(input logic [VOL_W-1:0] cur,
                                                    input logic [VOL_W-1:0] tgt);
      logic [VOL_W-1:0] res;
      if (cur < tgt) begin
         res = cur + 4'd1;
      end else if (cur > tgt) begin
         res = cur - 4'd1;
      end else begin
         res = cur;
      end
      return res;
   endfunction

endpackage

// File: rtl/mixer_fade_ctrl_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first set bit of the
// pending mask, searching upward (with wrap) from the channel after last_i.
module rr_pick #(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) (
   input  logic [N_CH-1:0] pending_i,
   input  logic [CH_W-1:0] last_i,
   output logic [CH_W-1:0] grant_o,
   output logic            found_o
);

   // Scan from last_i+1 around the ring; the first pending channel wins.
   always_comb begin
      grant_o = {CH_W{1'b0}};
      found_o = 1'b0;
      for (int off = 1; off <= N_CH; off++) begin
         if (!found_o && pending_i[(int'(last_i) + off) % N_CH]) begin
            grant_o = CH_W'((int'(last_i) + off) % N_CH);
            found_o = 1'b1;
         end else begin
            grant_o = grant_o;
         end
      end
   end

endmodule

// File: rtl/mixer_fade_ctrl.sv
// mixer_fade_ctrl: per-channel volume envelope scheduler. The CPU programs a
// target/period per channel; on each divider tick the current volume walks one
// step toward the target, and every changed volume is pushed to the mixer
// through a single-outstanding bus master with round-robin channel selection.
module mixer_fade_ctrl
   import mixer_pkg::*;
#(
   parameter int          N_CH     = 4,
   parameter int          TICK_DIV = 1000,
   parameter logic [31:0] MIX_BASE = 32'h0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid,
   output logic        ready,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [3:0]  m_wstrb,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        busy
);

   localparam int              CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [15:0]     DIV_LAST = 16'(TICK_DIV - 1);
   localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

   logic [15:0]      div_q, div_d;
   logic             tick_s;
   logic             ready_q;
   logic [31:0]      rdata_q, rdata_d;
   logic [VOL_W-1:0] cur_q    [N_CH];
   logic [VOL_W-1:0] cur_d    [N_CH];
   logic [VOL_W-1:0] target_q [N_CH];
   logic [VOL_W-1:0] target_d [N_CH];
   logic [VOL_W-1:0] period_q [N_CH];
   logic [VOL_W-1:0] period_d [N_CH];
   logic [VOL_W-1:0] pcnt_q   [N_CH];
   logic [VOL_W-1:0] pcnt_d   [N_CH];
   logic [N_CH-1:0]  pending_q, pending_d;
   state_e           state_q, state_d;
   logic [CH_W-1:0]  grant_q, grant_d;
   logic [CH_W-1:0]  last_grant_q, last_grant_d;
   logic             m_valid_q, m_valid_d;
   logic [3:0]       m_wstrb_q, m_wstrb_d;
   logic [31:0]      m_addr_q, m_addr_d;
   logic [31:0]      m_wdata_q, m_wdata_d;
   logic             busy_q, busy_d;
   logic [2:0]       reg_idx_s;
   logic             wr_s;
   logic [CH_W-1:0]  pick_s;
   logic             found_s;
   logic [31:0]      rd_val_s;
   logic             unused_s;

   assign reg_idx_s = addr[4:2];
   assign wr_s      = valid && wstrb[0];
   assign unused_s  = ^{addr[31:5], addr[1:0], wdata[31:8], wstrb[3:1]};

   rr_pick #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_rr_pick (
      .pending_i (pending_q),
      .last_i    (last_grant_q),
      .grant_o   (pick_s),
      .found_o   (found_s)
   );

   // Free-running divider; tick_s is high for one cycle every TICK_DIV cycles.
   always_comb begin
      tick_s = (div_q == DIV_LAST);
      if (tick_s) begin
         div_d = 16'd0;
      end else begin
         div_d = div_q + 16'd1;
      end
   end

   // Register read mux; STATUS is decoded first, unmapped indices read zero.
   always_comb begin
      rd_val_s = 32'd0;
      if (reg_idx_s == STATUS) begin
         rd_val_s = {16'd0, 8'(pending_q), 7'd0, busy_q};
      end else begin
         for (int ch = 0; ch < N_CH; ch++) begin
            if (int'(reg_idx_s) == ch) begin
               rd_val_s = {20'd0, cur_q[ch], period_q[ch], target_q[ch]};
            end else begin
               rd_val_s = rd_val_s;
            end
         end
      end
      if (valid && (wstrb == 4'd0)) begin
         rdata_d = rd_val_s;
      end else begin
         rdata_d = 32'd0;
      end
   end

   // Envelope update: CPU writes take priority over tick steps; a new pending
   // request from a change beats the clear issued by a same-cycle grant.
   always_comb begin
      pending_d = pending_q;
      if ((state_q == IDLE) && found_s) begin
         pending_d[pick_s] = 1'b0;
      end else begin
         pending_d = pending_q;
      end
      for (int ch = 0; ch < N_CH; ch++) begin
         cur_d[ch]    = cur_q[ch];
         target_d[ch] = target_q[ch];
         period_d[ch] = period_q[ch];
         pcnt_d[ch]   = pcnt_q[ch];
         if (wr_s && (int'(reg_idx_s) == ch)) begin
            target_d[ch] = wdata[3:0];
            period_d[ch] = wdata[7:4];
            pcnt_d[ch]   = 4'd0;
            if (wdata[7:4] == 4'd0) begin
               cur_d[ch]     = wdata[3:0];
               pending_d[ch] = 1'b1;
            end else begin
               cur_d[ch] = cur_q[ch];
            end
         end else if (tick_s && (cur_q[ch] != target_q[ch]) && (period_q[ch] != 4'd0)) begin
            if ((pcnt_q[ch] + 4'd1) == period_q[ch]) begin
               pcnt_d[ch]    = 4'd0;
               cur_d[ch]     = step_toward(cur_q[ch], target_q[ch]);
               pending_d[ch] = 1'b1;
            end else begin
               pcnt_d[ch] = pcnt_q[ch] + 4'd1;
            end
         end else begin
            pcnt_d[ch] = pcnt_q[ch];
         end
      end
   end

   // Master scheduler: latch one channel's write at grant, hold it until acked.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      m_valid_d    = m_valid_q;
      m_wstrb_d    = m_wstrb_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      case (state_q)
         IDLE: begin
            if (found_s) begin
               state_d   = WRITE;
               grant_d   = pick_s;
               m_valid_d = 1'b1;
               m_wstrb_d = 4'b0001;
               m_addr_d  = MIX_BASE + {{(30 - CH_W){1'b0}}, pick_s, 2'b00};
               m_wdata_d = {28'd0, cur_q[pick_s]};
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            if (m_ready) begin
               state_d      = IDLE;
               m_valid_d    = 1'b0;
               m_wstrb_d    = 4'b0000;
               last_grant_d = grant_q;
            end else begin
               state_d = WRITE;
            end
         end
         default: begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
            m_wstrb_d = 4'b0000;
         end
      endcase
      busy_d = (pending_d != {N_CH{1'b0}}) || (state_d == WRITE);
   end

   // State registers; reset drops the master request immediately.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q        <= 16'd0;
         ready_q      <= 1'b0;
         rdata_q      <= 32'd0;
         pending_q    <= {N_CH{1'b0}};
         state_q      <= IDLE;
         grant_q      <= {CH_W{1'b0}};
         last_grant_q <= LAST_CH;
         m_valid_q    <= 1'b0;
         m_wstrb_q    <= 4'b0000;
         m_addr_q     <= 32'd0;
         m_wdata_q    <= 32'd0;
         busy_q       <= 1'b0;
         for (int ch = 0; ch < N_CH; ch++) begin
            cur_q[ch]    <= 4'd0;
            target_q[ch] <= 4'd0;
            period_q[ch] <= 4'd0;
            pcnt_q[ch]   <= 4'd0;
         end
      end else begin
         div_q        <= div_d;
         ready_q      <= valid;
         rdata_q      <= rdata_d;
         pending_q    <= pending_d;
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         m_valid_q    <= m_valid_d;
         m_wstrb_q    <= m_wstrb_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         busy_q       <= busy_d;
         for (int ch = 0; ch < N_CH; ch++) begin
            cur_q[ch]    <= cur_d[ch];
            target_q[ch] <= target_d[ch];
            period_q[ch] <= period_d[ch];
            pcnt_q[ch]   <= pcnt_d[ch];
         end
      end
   end

   assign ready   = ready_q;
   assign rdata   = rdata_q;
   assign m_valid = m_valid_q;
   assign m_wstrb = m_wstrb_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign busy    = busy_q;

endmodule
